flow_step_ctrl: RTL and testbench

// Control stage directly upstream of the flowing-light up/down counter. Debounces three

---
 rtl/flow_step_ctrl.sv | 101 ++++++++++
 tb/tb_flow_step_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/flow_step_ctrl.sv
// flow_step_ctrl: debounced run/mode/clr buttons, step prescaler and en/u_d/r drive for an up/down counter
// Ports:
//   clk                      rising-edge system clock
//   r_n                      asynchronous active-low reset
//   btn_run/btn_mode/btn_clr raw push-buttons (press = accepted 0->1 level change)
//   q_in  [CNT_BITS]         downstream counter value, used for bounce turn-around
//   en                       one-cycle step pulse every DIV running cycles
//   u_d                      step direction, 1 = up
//   r                        one-cycle synchronous clear pulse for the counter
//   running                  1 while stepping
//   mode  [2]                0 up, 1 down, 2 bounce
module flow_step_ctrl #(
  parameter int CNT_BITS  = 3,
  parameter int DIV       = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                r_n,
  input  logic                btn_run,
  input  logic                btn_mode,
  input  logic                btn_clr,
  input  logic [CNT_BITS-1:0] q_in,
  output logic                en,
  output logic                u_d,
  output logic                r,
  output logic                running,
  output logic [1:0]          mode
);
  localparam int PW = $clog2(DIV);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] Q_MAX = '1;
  localparam logic [CNT_BITS-1:0] Q_PRE = Q_MAX - 1'b1;
  localparam logic [CNT_BITS-1:0] Q_ONE = CNT_BITS'(1);
  typedef enum logic {S_UP, S_DN} dir_t;
  typedef enum logic [1:0] {M_UP, M_DN, M_BNC} mode_t;
  logic [2:0] btn, s1_q, s2_q, lvl_q, lvl_d, prs_q, prs_d;
  logic [2:0][DW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic run_q, run_d, en_q, en_d, r_q;
  logic p_run, p_mode, p_clr;
  mode_t mode_q, mode_d;
  dir_t dir_q, dir_d;
  assign btn = {btn_clr, btn_mode, btn_run};
  assign {p_clr, p_mode, p_run} = prs_q;
  // debounce: count consecutive samples that disagree with the accepted level
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    prs_d = '0;
    for (int k = 0; k < 3; k++) begin
      cnt_d[k] = (s2_q[k] == lvl_q[k] || cnt_q[k] == DB_LAST) ? '0 : cnt_q[k] + 1'b1;
      lvl_d[k] = (s2_q[k] != lvl_q[k] && cnt_q[k] == DB_LAST) ? s2_q[k] : lvl_q[k];
      prs_d[k] = lvl_d[k] & ~lvl_q[k];
    end
  end
  // bounce turns around at the ends even before the direction register catches up
  assign u_d = (mode_q == M_UP) | ((mode_q == M_BNC) & (dir_q == S_UP ? q_in != Q_MAX : q_in == '0));
  always_comb begin
    run_d  = run_q ^ p_run;
    mode_d = p_mode ? (mode_q == M_BNC ? M_UP : mode_t'(mode_q + 2'd1)) : mode_q;
    pre_d  = p_clr ? '0 : !run_q ? pre_q : pre_q == P_LAST ? '0 : pre_q + 1'b1;
    en_d   = run_q & (pre_q == P_LAST) & ~p_clr;
    dir_d  = dir_q;
    if (p_clr | (p_mode & mode_q == M_DN)) dir_d = S_UP;
    else if (en_q & mode_q == M_BNC)
      dir_d = u_d ? (q_in == Q_PRE ? S_DN : S_UP) : (q_in == Q_ONE ? S_UP : S_DN);
  end
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      cnt_q  <= '0;
      lvl_q  <= '0;
      prs_q  <= '0;
      pre_q  <= '0;
      run_q  <= 1'b0;
      en_q   <= 1'b0;
      r_q    <= 1'b0;
      mode_q <= M_UP;
      dir_q  <= S_UP;
    end else begin
      s1_q   <= btn;
      s2_q   <= s1_q;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      prs_q  <= prs_d;
      pre_q  <= pre_d;
      run_q  <= run_d;
      en_q   <= en_d;
      r_q    <= p_clr;
      mode_q <= mode_d;
      dir_q  <= dir_d;
    end
  end
  assign en      = en_q;
  assign r       = r_q;
  assign running = run_q;
  assign mode    = mode_q;
endmodule

// File: tb/tb_flow_step_ctrl.sv
// tb_flow_step_ctrl: randomized scenario bench for flow_step_ctrl with an attached up/down counter
module tb_flow_step_ctrl;
  localparam int DIV = 4;
  localparam int MAX = 7;
  typedef struct {
    int         cyc;
    logic       ud;
    logic [2:0] q;
  } ev_t;
  logic clk = 1'b0, r_n = 1'b0, b_run = 1'b0, b_mode = 1'b0, b_clr = 1'b0;
  logic [2:0] cq;
  logic en, u_d, r, running;
  logic [1:0] mode;
  int pass_cnt = 0, total = 0, cyc = 0, both_cnt = 0;
  ev_t evq[$];
  int rq[$];
  flow_step_ctrl #(.CNT_BITS(3), .DIV(DIV), .DB_CYCLES(3)) dut (
    .clk(clk), .r_n(r_n), .btn_run(b_run), .btn_mode(b_mode), .btn_clr(b_clr),
    .q_in(cq), .en(en), .u_d(u_d), .r(r), .running(running), .mode(mode)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge r_n)
    if (!r_n) cq <= '0;
    else if (r) cq <= '0;
    else if (en) cq <= u_d ? cq + 3'd1 : cq - 3'd1;
  always @(negedge clk)
    if (r_n) begin
      ev_t e;
      e.cyc = cyc;
      e.ud  = u_d;
      e.q   = cq;
      if (en) evq.push_back(e);
      if (r) rq.push_back(cyc);
      if (en && r) both_cnt++;
    end
  function automatic int tri_q(input int p);
    return (p % 14) <= MAX ? p % 14 : 14 - (p % 14);
  endfunction
  function automatic logic tri_ud(input int p);
    return (p % 14) < MAX;
  endfunction
  task automatic do_reset();
    r_n = 1'b0;
    repeat (2) @(negedge clk);
    r_n = 1'b1;
    @(negedge clk);
    evq.delete();
    rq.delete();
    both_cnt = 0;
  endtask
  task automatic press(input logic [2:0] m, input int hold);
    @(negedge clk);
    {b_clr, b_mode, b_run} = m;
    repeat (hold) @(negedge clk);
    {b_clr, b_mode, b_run} = 3'b000;
    repeat (8) @(negedge clk);
  endtask
  task automatic wait_ev(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (evq.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic wait_en_q(input logic [2:0] v, input bit any, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (en && (any || cq == v)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic test_reset();
    r_n = 1'b0;
    #1;
    total++; if ({en, r, running, mode, u_d} !== 6'b000001) $display("FAIL reset_async: got en,r,run,mode,ud=%b want 000001", {en, r, running, mode, u_d}); else pass_cnt++;
    repeat (3) @(negedge clk);
    total++; if ({en, r, running, mode, u_d} !== 6'b000001) $display("FAIL reset_held: got %b want 000001", {en, r, running, mode, u_d}); else pass_cnt++;
    r_n = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (evq.size() !== 0 || running !== 1'b0) $display("FAIL reset_idle: got events=%0d running=%b want 0 0", evq.size(), running); else pass_cnt++;
  endtask
  task automatic test_up();
    bit ok;
    do_reset();
    press(3'b001, 6);
    total++; if (running !== 1'b1) $display("FAIL up_running: got %b want 1", running); else pass_cnt++;
    wait_ev(9, ok);
    total++; if (!ok) $display("FAIL up_timeout: got %0d events want 9", evq.size()); else pass_cnt++;
    for (int i = 0; i < 9 && i < evq.size(); i++) begin
      total++; if (evq[i].q !== 3'(i % 8) || evq[i].ud !== 1'b1) $display("FAIL up_step%0d: got q=%0d ud=%b want q=%0d ud=1", i, evq[i].q, evq[i].ud, i % 8); else pass_cnt++;
      if (i > 0) begin
        total++; if (evq[i].cyc - evq[i-1].cyc !== DIV) $display("FAIL up_gap%0d: got %0d want %0d", i, evq[i].cyc - evq[i-1].cyc, DIV); else pass_cnt++;
      end
    end
  endtask
  task automatic test_glitch();
    logic [2:0] m;
    int len;
    do_reset();
    repeat (6) begin
      m = 3'b001 << $urandom_range(0, 2);
      len = $urandom_range(1, 2);
      @(negedge clk);
      {b_clr, b_mode, b_run} = m;
      repeat (len) @(negedge clk);
      {b_clr, b_mode, b_run} = 3'b000;
      repeat (6) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    total++; if (running !== 1'b0 || mode !== 2'd0) $display("FAIL glitch_state: got run=%b mode=%0d want 0 0", running, mode); else pass_cnt++;
    total++; if (evq.size() !== 0 || rq.size() !== 0) $display("FAIL glitch_pulses: got en=%0d r=%0d want 0 0", evq.size(), rq.size()); else pass_cnt++;
  endtask
  task automatic test_bounce();
    bit ok;
    do_reset();
    press(3'b010, 6);
    press(3'b010, 6);
    total++; if (mode !== 2'd2) $display("FAIL bnc_mode: got %0d want 2", mode); else pass_cnt++;
    press(3'b001, 6);
    wait_ev(16, ok);
    total++; if (!ok) $display("FAIL bnc_timeout: got %0d events want 16", evq.size()); else pass_cnt++;
    for (int i = 0; i < 16 && i < evq.size(); i++) begin
      total++; if (evq[i].q !== 3'(tri_q(i)) || evq[i].ud !== tri_ud(i)) $display("FAIL bnc_step%0d: got q=%0d ud=%b want q=%0d ud=%b", i, evq[i].q, evq[i].ud, tri_q(i), tri_ud(i)); else pass_cnt++;
    end
  endtask
  task automatic test_bounce_at_max();
    bit ok;
    int v;
    do_reset();
    press(3'b010, 6);
    press(3'b001, 6);
    wait_en_q(3'd1, 1'b0, ok);
    total++; if (!ok) $display("FAIL max_timeout: got no step from q=1 want one"); else pass_cnt++;
    press(3'b001, 6);
    total++; if (running !== 1'b0) $display("FAIL max_paused: got %b want 0", running); else pass_cnt++;
    v = int'(cq);
    press(3'b010, 6);
    total++; if (u_d !== tri_ud(v)) $display("FAIL max_ud_entry: got %b want %b at q=%0d", u_d, tri_ud(v), v); else pass_cnt++;
    evq.delete();
    press(3'b001, 6);
    wait_ev(6, ok);
    total++; if (!ok) $display("FAIL max_run_timeout: got %0d events want 6", evq.size()); else pass_cnt++;
    for (int i = 0; i < 6 && i < evq.size(); i++) begin
      total++; if (evq[i].q !== 3'(tri_q(v + i)) || evq[i].ud !== tri_ud(v + i)) $display("FAIL max_step%0d: got q=%0d ud=%b want q=%0d ud=%b", i, evq[i].q, evq[i].ud, tri_q(v + i), tri_ud(v + i)); else pass_cnt++;
    end
  endtask
  task automatic test_clr();
    bit ok;
    int k;
    do_reset();
    press(3'b001, 6);
    wait_en_q(3'($urandom_range(1, 5)), 1'b0, ok);
    total++; if (!ok) $display("FAIL clr_timeout: got no trigger step want one"); else pass_cnt++;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    evq.delete();
    rq.delete();
    press(3'b100, 6);
    repeat (12) @(negedge clk);
    total++; if (rq.size() !== 1) $display("FAIL clr_r_count: got %0d want 1", rq.size()); else pass_cnt++;
    total++; if (both_cnt !== 0) $display("FAIL clr_r_and_en: got %0d want 0", both_cnt); else pass_cnt++;
    total++; if (running !== 1'b1 || mode !== 2'd0) $display("FAIL clr_keep: got run=%b mode=%0d want 1 0", running, mode); else pass_cnt++;
    k = 0;
    if (rq.size() > 0)
      foreach (evq[i])
        if (evq[i].cyc > rq[0]) begin
          total++; if (evq[i].q !== 3'(k) || evq[i].cyc - rq[0] !== DIV * (k + 1)) $display("FAIL clr_after%0d: got q=%0d dt=%0d want q=%0d dt=%0d", k, evq[i].q, evq[i].cyc - rq[0], k, DIV * (k + 1)); else pass_cnt++;
          k++;
        end
    total++; if (k < 2) $display("FAIL clr_steps: got %0d steps after clear want >=2", k); else pass_cnt++;
  endtask
  task automatic test_async_reset();
    bit ok;
    do_reset();
    press(3'b010, 6);
    press(3'b001, 6);
    wait_en_q(3'd0, 1'b1, ok);
    total++; if (!ok) $display("FAIL arst_timeout: got no en want one"); else pass_cnt++;
    #2 r_n = 1'b0;
    #1;
    total++; if ({en, r, running, mode, u_d} !== 6'b000001) $display("FAIL arst_mid: got en,r,run,mode,ud=%b want 000001", {en, r, running, mode, u_d}); else pass_cnt++;
    repeat (3) @(negedge clk);
    r_n = 1'b1;
    evq.delete();
    repeat (20) @(negedge clk);
    total++; if (evq.size() !== 0 || running !== 1'b0 || mode !== 2'd0) $display("FAIL arst_idle: got en=%0d run=%b mode=%0d want 0 0 0", evq.size(), running, mode); else pass_cnt++;
  endtask
  task automatic test_random_presses();
    logic [2:0] m;
    bit run_m;
    int md_m, nclr;
    do_reset();
    run_m = 1'b0;
    md_m = 0;
    nclr = 0;
    for (int t = 0; t < 12; t++) begin
      m = 3'($urandom_range(1, 7));
      press(m, $urandom_range(4, 8));
      if (m[0]) run_m = !run_m;
      if (m[1]) md_m = (md_m + 1) % 3;
      if (m[2]) nclr++;
      total++; if (running !== run_m || mode !== 2'(md_m)) $display("FAIL rnd_state%0d: got run=%b mode=%0d want run=%b mode=%0d", t, running, mode, run_m, md_m); else pass_cnt++;
    end
    total++; if (rq.size() !== nclr || both_cnt !== 0) $display("FAIL rnd_clr: got r=%0d overlap=%0d want r=%0d overlap=0", rq.size(), both_cnt, nclr); else pass_cnt++;
  endtask
  initial begin
    test_reset();
    test_up();
    test_glitch();
    test_bounce();
    test_bounce_at_max();
    test_clr();
    test_async_reset();
    test_random_presses();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
